// File: rtl/icache_direct_if.sv
// -----------------------------------------------------------------------------
// icache_direct_if
// Groups the signals between the instruction cache, the datapath fetch port and
// the memory controller.
//   Datapath side : imemREN, imemaddr (request)  -> ihit, imemload (response)
//   Memory side   : iREN, iaddr (request)        <- iwait, iload (response)
// Modports:
//   slave  - the cache: takes fetch requests and memory responses, and drives
//            the fetch response and the memory request.
//   master - the environment: the datapath and memory controller together.
// -----------------------------------------------------------------------------
interface icache_direct_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_direct.sv
// -----------------------------------------------------------------------------
// icache_direct
// Direct-mapped, one-word-per-block instruction cache in front of the
// datapath fetch port. Hits return in the same cycle. A miss blocks while one
// word is fetched over the iREN/iwait handshake, and that word is forwarded to
// the datapath in the completion cycle when the fetch address still matches.
// Ports:
//   CLK, RST    - clock (rising edge), asynchronous active-high reset
//   bus         - icache_direct_if.slave (fetch port and memory port)
//   hit_count   - fetch hits since reset (wraps)
//   miss_count  - misses started since reset (wraps)
// -----------------------------------------------------------------------------
module icache_direct #(
  parameter int SETS  = 16,
  parameter int CNT_W = 32
) (
  input  logic               CLK,
  input  logic               RST,
  icache_direct_if.slave     bus,
  output logic [CNT_W-1:0]   hit_count,
  output logic [CNT_W-1:0]   miss_count
);

  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = 30 - IDX;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b01,
    ST_FILL = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [29:0]        miss_word_q, miss_word_d;   // word address of the fill
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

  logic [SETS-1:0]    valid_q;
  logic [TAG_W-1:0]   tag_q  [SETS];
  logic [31:0]        data_q [SETS];

  // Fetch address split; the byte offset is not used by a word cache.
  logic [29:0]        fetch_word;
  logic [TAG_W-1:0]   fetch_tag;
  logic [IDX-1:0]     fetch_idx;
  logic               unused_addr_bits;
  logic               lookup_hit;

  logic [TAG_W-1:0]   fill_tag;
  logic [IDX-1:0]     fill_idx;
  logic               fill_we;

  logic               ihit_c;
  logic [31:0]        imemload_c;
  logic               iren_c;
  logic [31:0]        iaddr_c;

  assign fetch_word       = bus.imemaddr[31:2];
  assign fetch_tag        = fetch_word[29:IDX];
  assign fetch_idx        = fetch_word[IDX-1:0];
  assign unused_addr_bits = ^bus.imemaddr[1:0];
  assign fill_tag         = miss_word_q[29:IDX];
  assign fill_idx         = miss_word_q[IDX-1:0];

  assign lookup_hit = bus.imemREN && valid_q[fetch_idx] &&
                      (tag_q[fetch_idx] == fetch_tag);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    miss_word_d = miss_word_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    fill_we     = 1'b0;
    ihit_c      = 1'b0;
    imemload_c  = 32'h0;
    iren_c      = 1'b0;
    iaddr_c     = 32'h0;

    case (state_q)
      ST_IDLE: begin
        if (lookup_hit) begin
          ihit_c     = 1'b1;
          imemload_c = data_q[fetch_idx];
          hit_cnt_d  = hit_cnt_q + CNT_W'(1);
        end else if (bus.imemREN) begin
          miss_word_d = fetch_word;
          miss_cnt_d  = miss_cnt_q + CNT_W'(1);
          state_d     = ST_FILL;
        end
      end

      ST_FILL: begin
        iren_c  = 1'b1;
        iaddr_c = {miss_word_q, 2'b00};
        if (!bus.iwait) begin
          fill_we = 1'b1;
          state_d = ST_IDLE;
          // Forward the returning word only if the datapath still wants it;
          // it was already counted as a miss, so the hit counter stays put.
          if (bus.imemREN && (fetch_word == miss_word_q)) begin
            ihit_c     = 1'b1;
            imemload_c = bus.iload;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      miss_word_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_word_q <= miss_word_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      if (fill_we) valid_q[fill_idx] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays are deliberately left out of reset; the valid
  // bits alone make stale contents invisible, and the arrays can map to RAM.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.iload;
    end
  end

  assign bus.ihit     = ihit_c;
  assign bus.imemload = imemload_c;
  assign bus.iREN     = iren_c;
  assign bus.iaddr    = iaddr_c;
  assign hit_count    = hit_cnt_q;
  assign miss_count   = miss_cnt_q;

endmodule
